// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game-flow controller:
// FSM state encoding, text-overlay select codes and 2-digit BCD score.
package pong_pkg;

    typedef enum logic [1:0] {
        NEWGAME = 2'd0,
        PLAY    = 2'd1,
        SERVE   = 2'd2,
        OVER    = 2'd3
    } game_state_t;

    localparam logic [1:0] DISP_NEWGAME = 2'd0;
    localparam logic [1:0] DISP_PLAY    = 2'd1;
    localparam logic [1:0] DISP_SERVE   = 2'd2;
    localparam logic [1:0] DISP_OVER    = 2'd3;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    // 99 + 1 wraps to 00; unreachable with a legal winning score.
    function automatic bcd2_t bcd_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.ones == 4'd9) begin
            r.ones = 4'd0;
            r.tens = (v.tens == 4'd9) ? 4'd0 : v.tens + 4'd1;
        end else begin
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD score register with synchronous clear and increment.
module bcd_counter2
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] q
);

    bcd2_t cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= bcd_inc(cnt);
        end
    end

    assign q = cnt;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow FSM: scores point strobes, sequences new-game, serve delay,
// play and game-over phases, and drives the graphics freeze control.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter logic [7:0] WIN_SCORE   = 8'h11,
    parameter int         TIMER_TICKS = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh_tick,
    input  logic [3:0] btn,
    input  logic       pts_1,
    input  logic       pts_2,
    output logic       gra_still,
    output logic [7:0] score1,
    output logic [7:0] score2,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [1:0] disp_mode
);

    localparam logic [7:0] TIMER_LOAD = 8'(TIMER_TICKS);

    game_state_t state;
    logic [7:0]  timer;
    logic        pts_1_d;
    logic        pts_2_d;

    logic pt1_evt;
    logic pt2_evt;
    logic btn_any;
    logic in_play;
    logic inc1;
    logic inc2;
    logic clr_scores;
    logic win_hit;

    assign pt1_evt = pts_1 & ~pts_1_d;
    assign pt2_evt = pts_2 & ~pts_2_d;
    assign btn_any = (btn != 4'b0000);
    assign in_play = (state == PLAY);

    // Player 1 takes priority when both edges land in the same cycle.
    assign inc1 = in_play & pt1_evt;
    assign inc2 = in_play & pt2_evt & ~pt1_evt;

    assign win_hit = pt1_evt ? (bcd_inc(score1) == WIN_SCORE)
                             : (bcd_inc(score2) == WIN_SCORE);

    // Scores clear on the OVER -> NEWGAME transition.
    assign clr_scores = (state == OVER) && (timer == 8'd0);

    bcd_counter2 u_score1 (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_scores),
        .inc   (inc1),
        .q     (score1)
    );

    bcd_counter2 u_score2 (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_scores),
        .inc   (inc2),
        .q     (score2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= NEWGAME;
            timer     <= 8'd0;
            winner    <= 2'b00;
            gra_still <= 1'b1;
            game_over <= 1'b0;
            disp_mode <= DISP_NEWGAME;
            pts_1_d   <= 1'b0;
            pts_2_d   <= 1'b0;
        end else begin
            pts_1_d <= pts_1;
            pts_2_d <= pts_2;

            case (state)
                NEWGAME: begin
                    if (btn_any) begin
                        state     <= PLAY;
                        gra_still <= 1'b0;
                        disp_mode <= DISP_PLAY;
                    end
                end

                PLAY: begin
                    // Load is the only timer action here, so a coincident tick is dropped.
                    if (pt1_evt || pt2_evt) begin
                        timer     <= TIMER_LOAD;
                        gra_still <= 1'b1;
                        if (win_hit) begin
                            state     <= OVER;
                            winner    <= pt1_evt ? 2'b01 : 2'b10;
                            game_over <= 1'b1;
                            disp_mode <= DISP_OVER;
                        end else begin
                            state     <= SERVE;
                            disp_mode <= DISP_SERVE;
                        end
                    end
                end

                SERVE: begin
                    if (timer == 8'd0) begin
                        if (btn_any) begin
                            state     <= PLAY;
                            gra_still <= 1'b0;
                            disp_mode <= DISP_PLAY;
                        end
                    end else if (refresh_tick) begin
                        timer <= timer - 8'd1;
                    end
                end

                OVER: begin
                    if (timer == 8'd0) begin
                        state     <= NEWGAME;
                        winner    <= 2'b00;
                        game_over <= 1'b0;
                        disp_mode <= DISP_NEWGAME;
                    end else if (refresh_tick) begin
                        timer <= timer - 8'd1;
                    end
                end

                default: begin
                    state     <= NEWGAME;
                    gra_still <= 1'b1;
                    game_over <= 1'b0;
                    disp_mode <= DISP_NEWGAME;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl with default parameters
// (win at 8'h11, 120-tick serve and game-over delays).
module tb_pong_game_ctrl;

    logic       clk;
    logic       reset;
    logic       refresh_tick;
    logic [3:0] btn;
    logic       pts_1;
    logic       pts_2;
    logic       gra_still;
    logic [7:0] score1;
    logic [7:0] score2;
    logic       game_over;
    logic [1:0] winner;
    logic [1:0] disp_mode;

    int tests_run;
    int tests_failed;

    pong_game_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .refresh_tick (refresh_tick),
        .btn          (btn),
        .pts_1        (pts_1),
        .pts_2        (pts_2),
        .gra_still    (gra_still),
        .score1       (score1),
        .score2       (score2),
        .game_over    (game_over),
        .winner       (winner),
        .disp_mode    (disp_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        refresh_tick = 1'b1;
        step();
        refresh_tick = 1'b0;
        step();
    endtask

    task automatic point(input int player);
        if (player == 1) pts_1 = 1'b1;
        else             pts_2 = 1'b1;
        step();
        pts_1 = 1'b0;
        pts_2 = 1'b0;
        step();
    endtask

    task automatic serve_resume(input string tag);
        btn = 4'b0010;
        repeat (120) do_tick();
        step();
        btn = 4'b0000;
        check(tag, 32'(disp_mode), 32'd1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        refresh_tick = 1'b0;
        btn          = 4'b0000;
        pts_1        = 1'b0;
        pts_2        = 1'b0;
        repeat (2) step();
        #2 reset = 1'b0;
        step();

        check("rst_gra_still", 32'(gra_still), 32'd1);
        check("rst_disp_mode", 32'(disp_mode), 32'd0);
        check("rst_score1",    32'(score1),    32'h00);
        check("rst_score2",    32'(score2),    32'h00);
        check("rst_winner",    32'(winner),    32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);

        // Start game: one-cycle button press.
        btn = 4'b0001;
        check("start_pre_gra", 32'(gra_still), 32'd1);
        step();
        btn = 4'b0000;
        check("start_gra_still", 32'(gra_still), 32'd0);
        check("start_disp_play", 32'(disp_mode), 32'd1);

        // Hold pts_1 for 50 cycles: a single point only.
        pts_1 = 1'b1;
        step();
        check("pt1_score1_lat", 32'(score1),    32'h01);
        check("pt1_gra_still",  32'(gra_still), 32'd1);
        check("pt1_disp_serve", 32'(disp_mode), 32'd2);
        repeat (49) step();
        pts_1 = 1'b0;
        step();
        check("pt1_held_score1", 32'(score1), 32'h01);

        // No button: stays in SERVE well past the delay.
        repeat (130) do_tick();
        check("serve_idle_disp", 32'(disp_mode), 32'd2);
        check("serve_idle_gra",  32'(gra_still), 32'd1);
        btn = 4'b1000;
        step();
        btn = 4'b0000;
        check("serve_btn_play", 32'(disp_mode), 32'd1);

        // Point with a coincident tick (load wins), then exact 120-tick resume.
        pts_1        = 1'b1;
        refresh_tick = 1'b1;
        step();
        pts_1        = 1'b0;
        refresh_tick = 1'b0;
        btn          = 4'b0100;
        step();
        check("pt2_score1", 32'(score1), 32'h02);
        repeat (119) do_tick();
        check("tick119_serve", 32'(disp_mode), 32'd2);
        refresh_tick = 1'b1;
        step();
        refresh_tick = 1'b0;
        check("tick120_still_serve", 32'(disp_mode), 32'd2);
        step();
        btn = 4'b0000;
        check("tick120_play", 32'(disp_mode), 32'd1);
        check("tick120_gra",  32'(gra_still), 32'd0);

        // Simultaneous edges: player 1 credited only.
        pts_1 = 1'b1;
        pts_2 = 1'b1;
        step();
        pts_1 = 1'b0;
        pts_2 = 1'b0;
        step();
        check("both_score1", 32'(score1), 32'h03);
        check("both_score2", 32'(score2), 32'h00);
        serve_resume("both_resume");

        // Player 2 runs to the winning score across the BCD digit boundary.
        for (int i = 1; i <= 9; i++) begin
            point(2);
            if (i < 9) serve_resume("p2_resume");
        end
        check("p2_score_09", 32'(score2), 32'h09);
        serve_resume("p2_resume9");
        point(2);
        check("p2_score_10", 32'(score2), 32'h10);
        check("p2_score1_kept", 32'(score1), 32'h03);
        serve_resume("p2_resume10");
        point(2);
        check("win_score2",    32'(score2),    32'h11);
        check("win_winner",    32'(winner),    32'd2);
        check("win_game_over", 32'(game_over), 32'd1);
        check("win_disp_over", 32'(disp_mode), 32'd3);
        check("win_gra_still", 32'(gra_still), 32'd1);

        // Game-over delay ignores buttons and returns to NEWGAME.
        btn = 4'b1111;
        repeat (119) do_tick();
        check("over119_disp", 32'(disp_mode), 32'd3);
        refresh_tick = 1'b1;
        step();
        refresh_tick = 1'b0;
        btn          = 4'b0000;
        check("over120_disp", 32'(disp_mode), 32'd3);
        step();
        check("ng_disp",      32'(disp_mode), 32'd0);
        check("ng_score1",    32'(score1),    32'h00);
        check("ng_score2",    32'(score2),    32'h00);
        check("ng_winner",    32'(winner),    32'd0);
        check("ng_game_over", 32'(game_over), 32'd0);
        check("ng_gra_still", 32'(gra_still), 32'd1);

        // Asynchronous reset mid-SERVE with the timer at 57.
        btn = 4'b0001;
        step();
        btn = 4'b0000;
        point(1);
        repeat (63) do_tick();
        check("pre_rst_score1", 32'(score1),    32'h01);
        check("pre_rst_disp",   32'(disp_mode), 32'd2);
        #2 reset = 1'b1;
        #1;
        check("arst_score1",    32'(score1),    32'h00);
        check("arst_disp",      32'(disp_mode), 32'd0);
        check("arst_gra_still", 32'(gra_still), 32'd1);
        check("arst_winner",    32'(winner),    32'd0);
        check("arst_game_over", 32'(game_over), 32'd0);
        step();
        #2 reset = 1'b0;
        step();
        check("post_rst_disp", 32'(disp_mode), 32'd0);
        btn = 4'b0001;
        step();
        btn = 4'b0000;
        check("post_rst_play", 32'(disp_mode), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, tests run %0d", tests_run);
        $fatal(1, "timeout");
    end

endmodule
